// File: rtl/bus_src_arbiter_pkg.sv
// Shared types and constants for the 4-source bus arbiter and its mux select encoding.
package bus_pkg;

    localparam int NSRC = 4;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // One-hot bit for a source index, used to clear or mask a granted source.
    function automatic logic [NSRC-1:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/bus_src_arbiter_if.sv
// Source-side and bus-side signals of the arbiter; master = arbiter, slave = sources and consumer.
interface bus_src_arbiter_if
    import bus_pkg::*;
#(
    parameter int W = 4
);
    logic [NSRC-1:0]   src_valid;
    logic [NSRC*W-1:0] src_data;
    logic [NSRC-1:0]   src_ready;
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic [W-1:0]      c;
    logic [W-1:0]      d;
    logic              x;
    logic              y;
    logic              bus_valid;
    logic              bus_ready;

    modport master (
        input  src_valid, src_data, bus_ready,
        output src_ready, a, b, c, d, x, y, bus_valid
    );

    modport slave (
        output src_valid, src_data, bus_ready,
        input  src_ready, a, b, c, d, x, y, bus_valid
    );
endinterface

// File: rtl/bus_src_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request bit scanning upward from last+1, wrapping.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       any,
    output logic [1:0] idx
);

    logic       any_s;
    logic [1:0] idx_s;
    logic [1:0] cand_s;

    // Scan from the farthest candidate down so the nearest one after last wins.
    always_comb begin
        any_s  = 1'b0;
        idx_s  = 2'b00;
        cand_s = 2'b00;
        for (int k = 4; k >= 1; k--) begin
            cand_s = last + 2'(k);
            any_s  = any_s | req[cand_s];
            idx_s  = req[cand_s] ? cand_s : idx_s;
        end
    end

    assign any = any_s;
    assign idx = idx_s;

endmodule

// File: rtl/bus_src_arbiter.sv
// Captures four sources into one-deep holding registers and drives the mux select round-robin
// under a valid/ready handshake with the bus consumer.
module bus_src_arbiter
    import bus_pkg::*;
#(
    parameter int W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    bus_src_arbiter_if.master bus
);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [NSRC-1:0] full_r;
    logic [W-1:0]    hold_r [NSRC];
    logic [1:0]      last_r;
    logic [1:0]      sel_r;
    logic            bus_valid_r;

    logic [NSRC-1:0] cap_s;
    logic [NSRC-1:0] clr_s;
    logic [NSRC-1:0] mask_req_s;
    logic            handshake_s;
    logic            any_idle_s;
    logic [1:0]      idx_idle_s;
    logic            any_next_s;
    logic [1:0]      idx_next_s;
    logic            sel_load_s;
    logic [1:0]      sel_nxt_s;
    logic            bus_valid_nxt_s;

    assign handshake_s = bus_valid_r & bus.bus_ready;
    assign cap_s       = bus.src_valid & ~full_r;
    assign clr_s       = handshake_s ? onehot4(sel_r) : 4'b0000;
    // The post-handshake pick must not see the source being popped this edge.
    assign mask_req_s  = full_r & ~onehot4(sel_r);

    rr_pick4 u_pick_idle (
        .req  (full_r),
        .last (last_r),
        .any  (any_idle_s),
        .idx  (idx_idle_s)
    );

    rr_pick4 u_pick_next (
        .req  (mask_req_s),
        .last (sel_r),
        .any  (any_next_s),
        .idx  (idx_next_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_idle_s) begin
                    state_nxt_s = GRANT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT: begin
                if (handshake_s && !any_next_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GRANT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output logic: next values for the registered select and bus_valid.
    always_comb begin
        sel_load_s      = 1'b0;
        sel_nxt_s       = sel_r;
        bus_valid_nxt_s = bus_valid_r;
        case (state_r)
            IDLE: begin
                bus_valid_nxt_s = any_idle_s;
                if (any_idle_s) begin
                    sel_load_s = 1'b1;
                    sel_nxt_s  = idx_idle_s;
                end else begin
                    sel_load_s = 1'b0;
                end
            end
            GRANT: begin
                if (handshake_s) begin
                    bus_valid_nxt_s = any_next_s;
                    sel_load_s      = any_next_s;
                    sel_nxt_s       = any_next_s ? idx_next_s : sel_r;
                end else begin
                    bus_valid_nxt_s = 1'b1;
                end
            end
            default: begin
                bus_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath registers: holding regs, full flags, round-robin pointer, select and bus_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r      <= 4'b0000;
            last_r      <= 2'b11;
            sel_r       <= SEL_A;
            bus_valid_r <= 1'b0;
            for (int i = 0; i < NSRC; i++) begin
                hold_r[i] <= '0;
            end
        end else begin
            bus_valid_r <= bus_valid_nxt_s;
            full_r      <= (full_r | cap_s) & ~clr_s;
            if (sel_load_s) begin
                sel_r <= sel_nxt_s;
            end
            if (handshake_s) begin
                last_r <= sel_r;
            end
            for (int i = 0; i < NSRC; i++) begin
                if (cap_s[i]) begin
                    hold_r[i] <= bus.src_data[i*W +: W];
                end
            end
        end
    end

    assign bus.src_ready = ~full_r;
    assign bus.a         = hold_r[0];
    assign bus.b         = hold_r[1];
    assign bus.c         = hold_r[2];
    assign bus.d         = hold_r[3];
    assign bus.x         = sel_r[1];
    assign bus.y         = sel_r[0];
    assign bus.bus_valid = bus_valid_r;

endmodule

// File: tb/tb_bus_src_arbiter.sv
// Directed bench for bus_src_arbiter: reset, single source, full sweep, backpressure, fairness, async reset.
module tb_bus_src_arbiter;

    logic clk;
    logic rst_n;
    int   errors;
    int   total;

    bus_src_arbiter_if #(.W(4)) bif ();

    bus_src_arbiter #(.W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    logic [1:0] got_seq [16];
    logic [1:0] exp_seq [6];
    int         ngrant;

    initial begin
        errors        = 0;
        total         = 0;
        ngrant        = 0;
        rst_n         = 1'b0;
        bif.src_valid = 4'b0000;
        bif.src_data  = 16'h0000;
        bif.bus_ready = 1'b0;
        exp_seq       = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};

        // Reset state while rst_n is low
        #2;
        chk("rst_src_ready", {12'h000, bif.src_ready}, 16'h000F);
        chk("rst_bus_valid", {15'h0000, bif.bus_valid}, 16'h0000);
        chk("rst_abcd", {bif.d, bif.c, bif.b, bif.a}, 16'h0000);
        chk("rst_xy", {14'h0000, bif.x, bif.y}, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("rel_src_ready", {12'h000, bif.src_ready}, 16'h000F);
        chk("rel_bus_valid", {15'h0000, bif.bus_valid}, 16'h0000);

        // Single source c
        bif.src_valid = 4'b0100;
        bif.src_data  = 16'h0800;
        bif.bus_ready = 1'b1;
        tick();
        bif.src_valid = 4'b0000;
        chk("single_cap_ready", {12'h000, bif.src_ready}, 16'h000B);
        chk("single_cap_c", {12'h000, bif.c}, 16'h0008);
        chk("single_cap_bv", {15'h0000, bif.bus_valid}, 16'h0000);
        tick();
        chk("single_grant_bv", {15'h0000, bif.bus_valid}, 16'h0001);
        chk("single_grant_xy", {14'h0000, bif.x, bif.y}, 16'h0002);
        tick();
        chk("single_done_bv", {15'h0000, bif.bus_valid}, 16'h0000);
        chk("single_done_ready", {12'h000, bif.src_ready}, 16'h000F);
        tick();
        chk("single_idle_bv", {15'h0000, bif.bus_valid}, 16'h0000);

        // All four, starting from last = 3
        pulse_reset();
        bif.src_valid = 4'b1111;
        bif.src_data  = 16'hF810;
        bif.bus_ready = 1'b1;
        tick();
        bif.src_valid = 4'b0000;
        chk("all_cap_ready", {12'h000, bif.src_ready}, 16'h0000);
        chk("all_cap_abcd", {bif.d, bif.c, bif.b, bif.a}, 16'hF810);
        tick();
        chk("all_g0_bv", {15'h0000, bif.bus_valid}, 16'h0001);
        chk("all_g0_xy", {14'h0000, bif.x, bif.y}, 16'h0000);
        tick();
        chk("all_g1_xy", {14'h0000, bif.x, bif.y}, 16'h0001);
        chk("all_g1_ready", {12'h000, bif.src_ready}, 16'h0001);
        tick();
        chk("all_g2_xy", {14'h0000, bif.x, bif.y}, 16'h0002);
        tick();
        chk("all_g3_xy", {14'h0000, bif.x, bif.y}, 16'h0003);
        chk("all_g3_bv", {15'h0000, bif.bus_valid}, 16'h0001);
        tick();
        chk("all_end_bv", {15'h0000, bif.bus_valid}, 16'h0000);
        chk("all_end_ready", {12'h000, bif.src_ready}, 16'h000F);

        // Backpressure on b, with a and d arriving mid-grant
        bif.src_valid = 4'b0010;
        bif.src_data  = 16'h0010;
        bif.bus_ready = 1'b0;
        tick();
        bif.src_valid = 4'b0000;
        tick();
        chk("bp_grant_bv", {15'h0000, bif.bus_valid}, 16'h0001);
        chk("bp_grant_xy", {14'h0000, bif.x, bif.y}, 16'h0001);
        bif.src_valid = 4'b1001;
        bif.src_data  = 16'h6005;
        tick();
        bif.src_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold_xy", {14'h0000, bif.x, bif.y}, 16'h0001);
            chk("bp_hold_b", {12'h000, bif.b}, 16'h0001);
            chk("bp_hold_ready", {12'h000, bif.src_ready}, 16'h0004);
            chk("bp_hold_bv", {15'h0000, bif.bus_valid}, 16'h0001);
            if (i < 3) tick();
        end
        chk("bp_ad_data", {bif.d, bif.a}, 16'h0065);
        bif.bus_ready = 1'b1;
        tick();
        chk("bp_next_d", {14'h0000, bif.x, bif.y}, 16'h0003);
        tick();
        chk("bp_next_a", {14'h0000, bif.x, bif.y}, 16'h0000);
        tick();
        chk("bp_end_bv", {15'h0000, bif.bus_valid}, 16'h0000);

        // Fairness: sources 0 and 1 always requesting
        pulse_reset();
        bif.src_valid = 4'b0011;
        bif.src_data  = 16'h0043;
        bif.bus_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bif.bus_valid === 1'b1) begin
                got_seq[ngrant] = {bif.x, bif.y};
                ngrant++;
            end
        end
        chk("fair_count", 16'(ngrant), 16'd8);
        for (int i = 0; i < 6; i++) begin
            chk("fair_seq", {14'h0000, got_seq[i]}, {14'h0000, exp_seq[i]});
        end
        bif.src_valid = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        chk("fair_drain_bv", {15'h0000, bif.bus_valid}, 16'h0000);
        chk("fair_drain_ready", {12'h000, bif.src_ready}, 16'h000F);

        // Async reset while d is granted
        pulse_reset();
        bif.src_valid = 4'b1000;
        bif.src_data  = 16'hA000;
        bif.bus_ready = 1'b0;
        tick();
        bif.src_valid = 4'b0000;
        tick();
        chk("ar_pre_xy", {14'h0000, bif.x, bif.y}, 16'h0003);
        chk("ar_pre_bv", {15'h0000, bif.bus_valid}, 16'h0001);
        rst_n = 1'b0;
        #1;
        chk("ar_bv", {15'h0000, bif.bus_valid}, 16'h0000);
        chk("ar_ready", {12'h000, bif.src_ready}, 16'h000F);
        chk("ar_d", {12'h000, bif.d}, 16'h0000);
        rst_n = 1'b1;
        bif.src_valid = 4'b1001;
        bif.src_data  = 16'hC007;
        bif.bus_ready = 1'b1;
        tick();
        bif.src_valid = 4'b0000;
        tick();
        chk("ar_first_a", {14'h0000, bif.x, bif.y}, 16'h0000);
        chk("ar_first_data", {12'h000, bif.a}, 16'h0007);
        tick();
        chk("ar_second_d", {14'h0000, bif.x, bif.y}, 16'h0003);
        tick();
        chk("ar_end_bv", {15'h0000, bif.bus_valid}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, total);
        $finish;
    end

endmodule
